// File: rtl/aes128_encrypt_pipe.sv
// aes128_encrypt_pipe
//
// Fully pipelined AES-128 encryption datapath. One 128-bit plaintext block
// is accepted every clock and the ciphertext appears a fixed 40 clocks later.
// Each AES transform occupies one registered stage:
//   stage 0        AddRoundKey(round key 0)
//   rounds 1..9    SubBytes, ShiftRows, MixColumns, AddRoundKey
//   round 10       SubBytes, ShiftRows, AddRoundKey
// The round keys come from an external key-schedule block and are read
// combinationally by every stage, so key_schedule must stay stable while
// any block is in flight.
//
// Ports
//   clk           in   1     system clock, rising edge
//   rst           in   1     asynchronous active-high reset
//   in_valid      in   1     d_in holds a block this cycle
//   d_in          in   128   plaintext, byte0 = d_in[127:120]
//   key_schedule  in   1408  round-key words, w[i] = key_schedule[32*(43-i) +: 32]
//   d_out         out  128   ciphertext, same byte order as d_in
//   out_valid     out  1     d_out holds a finished block
//
// Configuration macro: AES_VALID_PIPE_EN
//   defined   -> a 40-deep valid shift register follows the data and
//                drives out_valid
//   undefined -> in_valid is ignored and out_valid is tied low
//
// State layout is column-major: byte k sits in row k%4, column k/4, so each
// 32-bit slice [127-32c -: 32] of the state is one column with row 0 on top.

module aes128_encrypt_pipe #(
  parameter int NR       = 10,
  parameter int NK_WORDS = 44
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [127:0]              d_in,
  input  logic [32*NK_WORDS-1:0]    key_schedule,
  output logic [127:0]              d_out,
  output logic                      out_valid
);

  localparam int NUM_STAGES = 4 * NR;

  localparam int KIND_ARK = 0;
  localparam int KIND_SB  = 1;
  localparam int KIND_SR  = 2;
  localparam int KIND_MC  = 3;

  // Standard AES S-box as a 256-entry ROM.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y;
    y = 8'h00;
    case (x)
      8'h00: y = 8'h63; 8'h01: y = 8'h7c; 8'h02: y = 8'h77; 8'h03: y = 8'h7b;
      8'h04: y = 8'hf2; 8'h05: y = 8'h6b; 8'h06: y = 8'h6f; 8'h07: y = 8'hc5;
      8'h08: y = 8'h30; 8'h09: y = 8'h01; 8'h0a: y = 8'h67; 8'h0b: y = 8'h2b;
      8'h0c: y = 8'hfe; 8'h0d: y = 8'hd7; 8'h0e: y = 8'hab; 8'h0f: y = 8'h76;
      8'h10: y = 8'hca; 8'h11: y = 8'h82; 8'h12: y = 8'hc9; 8'h13: y = 8'h7d;
      8'h14: y = 8'hfa; 8'h15: y = 8'h59; 8'h16: y = 8'h47; 8'h17: y = 8'hf0;
      8'h18: y = 8'had; 8'h19: y = 8'hd4; 8'h1a: y = 8'ha2; 8'h1b: y = 8'haf;
      8'h1c: y = 8'h9c; 8'h1d: y = 8'ha4; 8'h1e: y = 8'h72; 8'h1f: y = 8'hc0;
      8'h20: y = 8'hb7; 8'h21: y = 8'hfd; 8'h22: y = 8'h93; 8'h23: y = 8'h26;
      8'h24: y = 8'h36; 8'h25: y = 8'h3f; 8'h26: y = 8'hf7; 8'h27: y = 8'hcc;
      8'h28: y = 8'h34; 8'h29: y = 8'ha5; 8'h2a: y = 8'he5; 8'h2b: y = 8'hf1;
      8'h2c: y = 8'h71; 8'h2d: y = 8'hd8; 8'h2e: y = 8'h31; 8'h2f: y = 8'h15;
      8'h30: y = 8'h04; 8'h31: y = 8'hc7; 8'h32: y = 8'h23; 8'h33: y = 8'hc3;
      8'h34: y = 8'h18; 8'h35: y = 8'h96; 8'h36: y = 8'h05; 8'h37: y = 8'h9a;
      8'h38: y = 8'h07; 8'h39: y = 8'h12; 8'h3a: y = 8'h80; 8'h3b: y = 8'he2;
      8'h3c: y = 8'heb; 8'h3d: y = 8'h27; 8'h3e: y = 8'hb2; 8'h3f: y = 8'h75;
      8'h40: y = 8'h09; 8'h41: y = 8'h83; 8'h42: y = 8'h2c; 8'h43: y = 8'h1a;
      8'h44: y = 8'h1b; 8'h45: y = 8'h6e; 8'h46: y = 8'h5a; 8'h47: y = 8'ha0;
      8'h48: y = 8'h52; 8'h49: y = 8'h3b; 8'h4a: y = 8'hd6; 8'h4b: y = 8'hb3;
      8'h4c: y = 8'h29; 8'h4d: y = 8'he3; 8'h4e: y = 8'h2f; 8'h4f: y = 8'h84;
      8'h50: y = 8'h53; 8'h51: y = 8'hd1; 8'h52: y = 8'h00; 8'h53: y = 8'hed;
      8'h54: y = 8'h20; 8'h55: y = 8'hfc; 8'h56: y = 8'hb1; 8'h57: y = 8'h5b;
      8'h58: y = 8'h6a; 8'h59: y = 8'hcb; 8'h5a: y = 8'hbe; 8'h5b: y = 8'h39;
      8'h5c: y = 8'h4a; 8'h5d: y = 8'h4c; 8'h5e: y = 8'h58; 8'h5f: y = 8'hcf;
      8'h60: y = 8'hd0; 8'h61: y = 8'hef; 8'h62: y = 8'haa; 8'h63: y = 8'hfb;
      8'h64: y = 8'h43; 8'h65: y = 8'h4d; 8'h66: y = 8'h33; 8'h67: y = 8'h85;
      8'h68: y = 8'h45; 8'h69: y = 8'hf9; 8'h6a: y = 8'h02; 8'h6b: y = 8'h7f;
      8'h6c: y = 8'h50; 8'h6d: y = 8'h3c; 8'h6e: y = 8'h9f; 8'h6f: y = 8'ha8;
      8'h70: y = 8'h51; 8'h71: y = 8'ha3; 8'h72: y = 8'h40; 8'h73: y = 8'h8f;
      8'h74: y = 8'h92; 8'h75: y = 8'h9d; 8'h76: y = 8'h38; 8'h77: y = 8'hf5;
      8'h78: y = 8'hbc; 8'h79: y = 8'hb6; 8'h7a: y = 8'hda; 8'h7b: y = 8'h21;
      8'h7c: y = 8'h10; 8'h7d: y = 8'hff; 8'h7e: y = 8'hf3; 8'h7f: y = 8'hd2;
      8'h80: y = 8'hcd; 8'h81: y = 8'h0c; 8'h82: y = 8'h13; 8'h83: y = 8'hec;
      8'h84: y = 8'h5f; 8'h85: y = 8'h97; 8'h86: y = 8'h44; 8'h87: y = 8'h17;
      8'h88: y = 8'hc4; 8'h89: y = 8'ha7; 8'h8a: y = 8'h7e; 8'h8b: y = 8'h3d;
      8'h8c: y = 8'h64; 8'h8d: y = 8'h5d; 8'h8e: y = 8'h19; 8'h8f: y = 8'h73;
      8'h90: y = 8'h60; 8'h91: y = 8'h81; 8'h92: y = 8'h4f; 8'h93: y = 8'hdc;
      8'h94: y = 8'h22; 8'h95: y = 8'h2a; 8'h96: y = 8'h90; 8'h97: y = 8'h88;
      8'h98: y = 8'h46; 8'h99: y = 8'hee; 8'h9a: y = 8'hb8; 8'h9b: y = 8'h14;
      8'h9c: y = 8'hde; 8'h9d: y = 8'h5e; 8'h9e: y = 8'h0b; 8'h9f: y = 8'hdb;
      8'ha0: y = 8'he0; 8'ha1: y = 8'h32; 8'ha2: y = 8'h3a; 8'ha3: y = 8'h0a;
      8'ha4: y = 8'h49; 8'ha5: y = 8'h06; 8'ha6: y = 8'h24; 8'ha7: y = 8'h5c;
      8'ha8: y = 8'hc2; 8'ha9: y = 8'hd3; 8'haa: y = 8'hac; 8'hab: y = 8'h62;
      8'hac: y = 8'h91; 8'had: y = 8'h95; 8'hae: y = 8'he4; 8'haf: y = 8'h79;
      8'hb0: y = 8'he7; 8'hb1: y = 8'hc8; 8'hb2: y = 8'h37; 8'hb3: y = 8'h6d;
      8'hb4: y = 8'h8d; 8'hb5: y = 8'hd5; 8'hb6: y = 8'h4e; 8'hb7: y = 8'ha9;
      8'hb8: y = 8'h6c; 8'hb9: y = 8'h56; 8'hba: y = 8'hf4; 8'hbb: y = 8'hea;
      8'hbc: y = 8'h65; 8'hbd: y = 8'h7a; 8'hbe: y = 8'hae; 8'hbf: y = 8'h08;
      8'hc0: y = 8'hba; 8'hc1: y = 8'h78; 8'hc2: y = 8'h25; 8'hc3: y = 8'h2e;
      8'hc4: y = 8'h1c; 8'hc5: y = 8'ha6; 8'hc6: y = 8'hb4; 8'hc7: y = 8'hc6;
      8'hc8: y = 8'he8; 8'hc9: y = 8'hdd; 8'hca: y = 8'h74; 8'hcb: y = 8'h1f;
      8'hcc: y = 8'h4b; 8'hcd: y = 8'hbd; 8'hce: y = 8'h8b; 8'hcf: y = 8'h8a;
      8'hd0: y = 8'h70; 8'hd1: y = 8'h3e; 8'hd2: y = 8'hb5; 8'hd3: y = 8'h66;
      8'hd4: y = 8'h48; 8'hd5: y = 8'h03; 8'hd6: y = 8'hf6; 8'hd7: y = 8'h0e;
      8'hd8: y = 8'h61; 8'hd9: y = 8'h35; 8'hda: y = 8'h57; 8'hdb: y = 8'hb9;
      8'hdc: y = 8'h86; 8'hdd: y = 8'hc1; 8'hde: y = 8'h1d; 8'hdf: y = 8'h9e;
      8'he0: y = 8'he1; 8'he1: y = 8'hf8; 8'he2: y = 8'h98; 8'he3: y = 8'h11;
      8'he4: y = 8'h69; 8'he5: y = 8'hd9; 8'he6: y = 8'h8e; 8'he7: y = 8'h94;
      8'he8: y = 8'h9b; 8'he9: y = 8'h1e; 8'hea: y = 8'h87; 8'heb: y = 8'he9;
      8'hec: y = 8'hce; 8'hed: y = 8'h55; 8'hee: y = 8'h28; 8'hef: y = 8'hdf;
      8'hf0: y = 8'h8c; 8'hf1: y = 8'ha1; 8'hf2: y = 8'h89; 8'hf3: y = 8'h0d;
      8'hf4: y = 8'hbf; 8'hf5: y = 8'he6; 8'hf6: y = 8'h42; 8'hf7: y = 8'h68;
      8'hf8: y = 8'h41; 8'hf9: y = 8'h99; 8'hfa: y = 8'h2d; 8'hfb: y = 8'h0f;
      8'hfc: y = 8'hb0; 8'hfd: y = 8'h54; 8'hfe: y = 8'hbb; 8'hff: y = 8'h16;
    endcase
    return y;
  endfunction

  // SubBytes is byte-wise, so the byte order of the state does not matter.
  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      r[8*k +: 8] = sbox(s[8*k +: 8]);
    end
    return r;
  endfunction

  // Row `row` is rotated left by `row` columns: the byte landing in column c
  // comes from column (c + row) % 4 of the same row.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127 - 8*(4*c + row) -: 8] = s[127 - 8*(4*((c + row) % 4) + row) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column times the circulant matrix [2 3 1 1]; 3*a is xtime(a) ^ a.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      r[127 - 32*c -: 32] = mix_column(s[127 - 32*c -: 32]);
    end
    return r;
  endfunction

  logic [127:0] stage_d [NUM_STAGES];
  logic [127:0] pipe_q  [NUM_STAGES];

  // Stage s applies one transform to the previous stage's register. Stage 0
  // is the initial key whitening; after that the rounds repeat the
  // SB/SR/MC/ARK pattern, except the last stage, which is the final
  // AddRoundKey because round 10 has no MixColumns.
  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    localparam int ROUND = (s == 0) ? 0 : (s - 1) / 4 + 1;
    localparam int KIND  = (s == 0)              ? KIND_ARK :
                           (s == NUM_STAGES - 1) ? KIND_ARK :
                           ((s - 1) % 4 + 1) % 4;

    logic [127:0] stage_in;

    if (s == 0) begin : g_src_in
      assign stage_in = d_in;
    end else begin : g_src_prev
      assign stage_in = pipe_q[s-1];
    end

    // Round key r is words w[4r..4r+3], which sit contiguously in the bus
    // with w[4r] in the top 32 bits.
    if (KIND == KIND_ARK) begin : g_ark
      assign stage_d[s] = stage_in ^ key_schedule[128*(NR - ROUND) +: 128];
    end else if (KIND == KIND_SB) begin : g_sb
      assign stage_d[s] = sub_bytes(stage_in);
    end else if (KIND == KIND_SR) begin : g_sr
      assign stage_d[s] = shift_rows(stage_in);
    end else begin : g_mc
      assign stage_d[s] = mix_columns(stage_in);
    end
  end

  // Data registers load every cycle; nothing stalls the pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        pipe_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        pipe_q[s] <= stage_d[s];
      end
    end
  end

  assign d_out = pipe_q[NUM_STAGES-1];

`ifdef AES_VALID_PIPE_EN
  logic [NUM_STAGES-1:0] valid_q;

  // Valid bit travels alongside its block so out_valid marks the block on d_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= {valid_q[NUM_STAGES-2:0], in_valid};
    end
  end

  assign out_valid = valid_q[NUM_STAGES-1];
`else
  // Without the valid pipe every cycle's d_in is encrypted and consumers
  // count 40 cycles themselves.
  logic unused_in_valid;
  assign unused_in_valid = in_valid;
  assign out_valid       = 1'b0;
`endif

endmodule

// File: tb/tb_aes128_encrypt_pipe.sv
// tb_aes128_encrypt_pipe
//
// Self-checking bench for aes128_encrypt_pipe. The reference is a plain
// software AES-128: the S-box is derived from GF(2^8) inversion plus the
// affine map, the key is expanded here, and MixColumns uses a generic GF
// multiply. Inputs change and outputs are sampled on the falling clock edge.
// Compile with AES_VALID_PIPE_EN defined to exercise the valid pipeline.

module tb_aes128_encrypt_pipe;

  localparam int LATENCY = 40;
`ifdef AES_VALID_PIPE_EN
  localparam bit VALID_EN = 1'b1;
`else
  localparam bit VALID_EN = 1'b0;
`endif

  logic          tb_clk;
  logic          rst;
  logic          in_valid;
  logic [127:0]  d_in;
  logic [1407:0] key_schedule;
  logic [127:0]  d_out;
  logic          out_valid;

  logic [31:0]   w_ref    [44];
  logic [7:0]    sbox_tab [256];
  int            check_count;
  int            pass_count;

  aes128_encrypt_pipe dut (
    .clk          (tb_clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .d_in         (d_in),
    .key_schedule (key_schedule),
    .d_out        (d_out),
    .out_valid    (out_valid)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] mix_coef(input int k);
    case (k)
      0:       return 8'h02;
      1:       return 8'h03;
      default: return 8'h01;
    endcase
  endfunction

  task automatic build_sbox();
    logic [7:0] x, y, inv;
    for (int i = 0; i < 256; i++) begin
      x   = 8'(i);
      inv = 8'h00;
      for (int j = 1; j < 256; j++) begin
        y = 8'(j);
        if (gmul(x, y) == 8'h01) inv = y;
      end
      sbox_tab[i] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                    {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic set_key(input logic [127:0] key);
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w_ref[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w_ref[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w_ref[i] = w_ref[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) key_schedule[32*(43 - i) +: 32] = w_ref[i];
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt);
    logic [7:0]   st [4][4];
    logic [7:0]   sh [4][4];
    logic [7:0]   acc;
    logic [127:0] ct;
    ct = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = pt[127 - 8*(4*c + r) -: 8] ^ w_ref[c][31 - 8*r -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          sh[r][c] = sbox_tab[st[r][(c + r) % 4]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          if (rnd < 10) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul(mix_coef((j - r + 4) % 4), sh[j][c]);
          end else begin
            acc = sh[r][c];
          end
          st[r][c] = acc ^ w_ref[4*rnd + c][31 - 8*r -: 8];
        end
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        ct[127 - 8*(4*c + r) -: 8] = st[r][c];
    return ct;
  endfunction

  function automatic logic [127:0] rand_block();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Present one block and advance to the next falling edge.
  task automatic push(input logic [127:0] blk, input logic v);
    d_in     = blk;
    in_valid = v;
    @(negedge tb_clk);
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    d_in     = rand_block();
    @(negedge tb_clk);
    @(negedge tb_clk);
    check_count++;
    if (d_out !== 128'h0) $display("[TB] FAIL reset_d_out: got %h expected %h", d_out, 128'h0);
    else pass_count++;
    check_count++;
    if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected %b", out_valid, 1'b0);
    else pass_count++;
    rst = 1'b0;
  endtask

  task automatic test_known_answer();
    logic [127:0] keys [3];
    logic [127:0] pts  [3];
    logic [127:0] cts  [3];
    logic [127:0] prior, prior_exp;
    keys = '{128'h000102030405060708090a0b0c0d0e0f, 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    pts  = '{128'h00112233445566778899aabbccddeeff, 128'h3243f6a8885a308d313198a2e0370734, 128'h0};
    cts  = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h3925841d02dc09fbdc118597196a0b32,
             128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    for (int v = 0; v < 3; v++) begin
      set_key(keys[v]);
      prior     = rand_block();
      prior_exp = aes_ref(prior);
      push(prior, 1'b1);
      push(pts[v], 1'b1);
      for (int i = 0; i < LATENCY - 2; i++) push(rand_block(), 1'b1);
      check_count++;
      if (d_out !== prior_exp) $display("[TB] FAIL kat%0d_preceding: got %h expected %h", v, d_out, prior_exp);
      else pass_count++;
      push(rand_block(), 1'b1);
      check_count++;
      if (d_out !== cts[v]) $display("[TB] FAIL kat%0d_cipher: got %h expected %h", v, d_out, cts[v]);
      else pass_count++;
      check_count++;
      if (out_valid !== VALID_EN) $display("[TB] FAIL kat%0d_out_valid: got %b expected %b", v, out_valid, VALID_EN);
      else pass_count++;
    end
  endtask

  task automatic test_back_to_back();
    logic [119:0] tail;
    logic [7:0]   firsts [4];
    logic [127:0] blk    [4];
    logic [127:0] expv   [4];
    tail   = "ukeimyourfather";
    firsts = '{8'h6c, 8'h64, 8'h73, 8'h79};
    set_key("lukeimyourfather");
    for (int i = 0; i < 4; i++) begin
      blk[i]  = {firsts[i], tail};
      expv[i] = aes_ref(blk[i]);
    end
    for (int i = 0; i < 4; i++) push(blk[i], 1'b1);
    for (int i = 0; i < LATENCY - 4; i++) push(rand_block(), 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) push(rand_block(), 1'b1);
      check_count++;
      if (d_out !== expv[i]) $display("[TB] FAIL back_to_back%0d: got %h expected %h", i, d_out, expv[i]);
      else pass_count++;
    end
  endtask

  task automatic test_random_stream();
    logic [127:0] expv [16];
    logic [127:0] blk;
    for (int k = 0; k < 3; k++) begin
      set_key(rand_block());
      for (int cyc = 0; cyc < 16 + LATENCY - 1; cyc++) begin
        blk = rand_block();
        if (cyc < 16) expv[cyc] = aes_ref(blk);
        push(blk, 1'b1);
        if (cyc >= LATENCY - 1) begin
          check_count++;
          if (d_out !== expv[cyc - (LATENCY - 1)])
            $display("[TB] FAIL random_k%0d_b%0d: got %h expected %h", k, cyc - (LATENCY - 1), d_out, expv[cyc - (LATENCY - 1)]);
          else pass_count++;
        end
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    logic [127:0] first_exp;
    logic [127:0] blk;
    logic         exp_valid;
    set_key(rand_block());
    for (int i = 0; i < 12; i++) push(rand_block(), 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_count++;
    if (d_out !== 128'h0) $display("[TB] FAIL midreset_async_d_out: got %h expected %h", d_out, 128'h0);
    else pass_count++;
    check_count++;
    if (out_valid !== 1'b0) $display("[TB] FAIL midreset_async_out_valid: got %b expected %b", out_valid, 1'b0);
    else pass_count++;
    for (int i = 0; i < 3; i++) begin
      push(rand_block(), 1'b1);
      check_count++;
      if (d_out !== 128'h0) $display("[TB] FAIL midreset_hold%0d: got %h expected %h", i, d_out, 128'h0);
      else pass_count++;
    end
    rst       = 1'b0;
    first_exp = '0;
    for (int k = 1; k <= LATENCY; k++) begin
      blk = rand_block();
      if (k == 1) first_exp = aes_ref(blk);
      push(blk, 1'b1);
      exp_valid = (k == LATENCY) ? VALID_EN : 1'b0;
      check_count++;
      if (out_valid !== exp_valid) $display("[TB] FAIL post_reset_valid%0d: got %b expected %b", k, out_valid, exp_valid);
      else pass_count++;
    end
    check_count++;
    if (d_out !== first_exp) $display("[TB] FAIL post_reset_first_block: got %h expected %h", d_out, first_exp);
    else pass_count++;
  endtask

  task automatic test_valid_pipe();
    logic [127:0] blk, blk_exp;
    logic         exp_valid;
    set_key(rand_block());
    for (int i = 0; i < LATENCY + 5; i++) push(rand_block(), 1'b0);
    check_count++;
    if (out_valid !== 1'b0) $display("[TB] FAIL valid_idle: got %b expected %b", out_valid, 1'b0);
    else pass_count++;
    blk     = rand_block();
    blk_exp = aes_ref(blk);
    push(blk, 1'b1);
    for (int k = 2; k <= LATENCY + 6; k++) begin
      push(rand_block(), 1'b0);
      exp_valid = (k == LATENCY) ? VALID_EN : 1'b0;
      check_count++;
      if (out_valid !== exp_valid) $display("[TB] FAIL valid_pulse_k%0d: got %b expected %b", k, out_valid, exp_valid);
      else pass_count++;
      if (k == LATENCY) begin
        check_count++;
        if (d_out !== blk_exp) $display("[TB] FAIL valid_pulse_data: got %h expected %h", d_out, blk_exp);
        else pass_count++;
      end
    end
  endtask

  initial begin
    check_count  = 0;
    pass_count   = 0;
    rst          = 1'b1;
    in_valid     = 1'b0;
    d_in         = '0;
    key_schedule = '0;
    build_sbox();
    $display("[TB] starting aes128_encrypt_pipe bench, valid pipe %0d", VALID_EN);
    test_reset();
    test_known_answer();
    test_back_to_back();
    test_random_stream();
    test_reset_mid_stream();
    test_valid_pipe();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
